mem_read_data_decoder: RTL and testbench

MEM_READ_DATA_DECODER -- requirements
Module: mem_read_data_decoder

---
 rtl/mem_read_data_decoder_if.sv | 47 ++++
 rtl/mem_read_data_decoder.sv | 163 ++++++++++++++++
 tb/tb_mem_read_data_decoder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_read_data_decoder_if.sv
// ---------------------------------------------------------------------------
// mem_read_data_decoder_if
// Groups the load-request, memory-return and response signals of the load
// data decoder into one bundle.
//
// Signals:
//   mRead     load request strobe (accepted when reqReady is also high)
//   Offs      byte offset of the access within the 32-bit word
//   dSize     access size: 00 word, 01 halfword, 10 byte, 11 reserved
//   signExt   1 sign-extends, 0 zero-extends sub-word loads
//   reqReady  decoder can accept a request
//   memData   raw word returned by memory
//   memValid  memData valid this cycle
//   dOut      decoded, extended load result
//   dValid    dOut valid
//   dReady    consumer accepts dOut
//   busErr    qualifies dValid: reserved size or timeout
//   misAlign  qualifies dValid: misaligned access
//
// Modports:
//   master  requester / memory / consumer side (drives requests and data)
//   slave   the decoder itself
// ---------------------------------------------------------------------------
interface mem_read_data_decoder_if;
    logic        mRead;
    logic [1:0]  Offs;
    logic [1:0]  dSize;
    logic        signExt;
    logic        reqReady;
    logic [31:0] memData;
    logic        memValid;
    logic [31:0] dOut;
    logic        dValid;
    logic        dReady;
    logic        busErr;
    logic        misAlign;

    modport master (
        output mRead, Offs, dSize, signExt, memData, memValid, dReady,
        input  reqReady, dOut, dValid, busErr, misAlign
    );

    modport slave (
        input  mRead, Offs, dSize, signExt, memData, memValid, dReady,
        output reqReady, dOut, dValid, busErr, misAlign
    );
endinterface

// File: rtl/mem_read_data_decoder.sv
// ---------------------------------------------------------------------------
// mem_read_data_decoder
// Accepts a load request (offset, size, sign mode), waits for the memory
// word, extracts the addressed byte/halfword (big-endian lane order: offset
// 00 is bits [31:24]), extends it and holds the result until the consumer
// takes it. A reserved size or a memory timeout returns busErr with dOut=0.
//
// Parameters:
//   TIMEOUT  max WAIT cycles without memValid before bus error (1..255)
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous, active-low reset
//   bus    mem_read_data_decoder_if.slave (request, memory and response)
//
// Optional feature:
//   MEM_RDEC_ALIGN_CHECK_EN  when defined, a halfword with Offs[0]=1 or a
//   word with Offs!=00 is answered one cycle after acceptance with
//   misAlign=1, busErr=0, dOut=0 and never waits for memory. When undefined
//   the unused offset bits are ignored and misAlign stays 0.
// ---------------------------------------------------------------------------
module mem_read_data_decoder #(
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mem_read_data_decoder_if.slave  bus
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_n;
    logic [1:0]     offs_r, offs_n;
    logic [1:0]     size_r, size_n;
    logic           sext_r, sext_n;
    logic [CW-1:0]  cnt_r, cnt_n;
    logic [31:0]    dout_r, dout_n;
    logic           err_r, err_n;
    logic           mis_r, mis_n;
    logic           misaligned;

    // Lane select plus extension. Signed locals make the size cast
    // replicate the top bit; the unsigned concatenation zero-fills.
    function automatic logic [31:0] decode(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic [1:0]  offs,
                                           input logic        sext);
        logic signed [15:0] half_sel;
        logic signed [7:0]  byte_sel;
        logic [31:0]        res;
        half_sel = offs[1] ? word[15:0] : word[31:16];
        case (offs)
            2'b00:   byte_sel = word[31:24];
            2'b01:   byte_sel = word[23:16];
            2'b10:   byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        case (size)
            2'b00:   res = word;
            2'b01:   res = sext ? 32'(half_sel) : {16'h0000, half_sel};
            2'b10:   res = sext ? 32'(byte_sel) : {24'h000000, byte_sel};
            default: res = '0;
        endcase
        return res;
    endfunction

`ifdef MEM_RDEC_ALIGN_CHECK_EN
    assign misaligned = ((bus.dSize == 2'b01) && bus.Offs[0]) ||
                        ((bus.dSize == 2'b00) && (bus.Offs != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // reqReady is gated by rst_n so nothing looks acceptable during reset.
    assign bus.reqReady = (state == IDLE) && rst_n;
    assign bus.dValid   = (state == RESP);
    assign bus.dOut     = dout_r;
    assign bus.busErr   = err_r;
    assign bus.misAlign = mis_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            offs_r <= '0;
            size_r <= '0;
            sext_r <= 1'b0;
            cnt_r  <= '0;
            dout_r <= '0;
            err_r  <= 1'b0;
            mis_r  <= 1'b0;
        end else begin
            state  <= state_n;
            offs_r <= offs_n;
            size_r <= size_n;
            sext_r <= sext_n;
            cnt_r  <= cnt_n;
            dout_r <= dout_n;
            err_r  <= err_n;
            mis_r  <= mis_n;
        end
    end

    always_comb begin
        state_n = state;
        offs_n  = offs_r;
        size_n  = size_r;
        sext_n  = sext_r;
        cnt_n   = cnt_r;
        dout_n  = dout_r;
        err_n   = err_r;
        mis_n   = mis_r;
        case (state)
            IDLE: begin
                if (bus.mRead) begin
                    offs_n = bus.Offs;
                    size_n = bus.dSize;
                    sext_n = bus.signExt;
                    cnt_n  = '0;
                    dout_n = '0;
                    err_n  = 1'b0;
                    mis_n  = 1'b0;
                    if (bus.dSize == 2'b11) begin
                        err_n   = 1'b1;
                        state_n = RESP;
                    end else if (misaligned) begin
                        mis_n   = 1'b1;
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                // Data arriving on the last allowed cycle beats the timeout.
                if (bus.memValid) begin
                    dout_n  = decode(bus.memData, size_r, offs_r, sext_r);
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_n   = CW'(TIMEOUT);
                    dout_n  = '0;
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
            RESP: begin
                if (bus.dReady) begin
                    dout_n  = '0;
                    err_n   = 1'b0;
                    mis_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_read_data_decoder.sv
// ---------------------------------------------------------------------------
// tb_mem_read_data_decoder
// Self-checking bench for mem_read_data_decoder (TIMEOUT=4): directed loads
// for the documented examples, timeout, reset during a transaction, then
// randomized loads compared with a byte-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mem_read_data_decoder;

    localparam int TO = 4;
`ifdef MEM_RDEC_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_read_data_decoder_if bus ();

    mem_read_data_decoder #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference: pick bytes by big-endian index arithmetic, extend numerically.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int size,
                                             input int offs, input bit sext);
        int     nbytes;
        int     start;
        longint v;
        longint span;
        if (size == 0) return w;
        nbytes = (size == 1) ? 2 : 1;
        start  = (size == 1) ? (offs / 2) * 2 : offs;
        span   = longint'(1) << (8 * nbytes);
        v      = (longint'(w) >> (8 * (4 - start - nbytes))) % span;
        if (sext && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic bit ref_misaligned(input int size, input int offs);
        return ALIGN_EN && ((size == 1 && (offs % 2) == 1) || (size == 0 && offs != 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete load: accept, wait lat idle WAIT cycles (data on the next
    // one, unless the timeout comes first), hold the response hold cycles.
    task automatic do_load(input int size, input int offs, input bit sext,
                           input logic [31:0] data, input int lat, input int hold);
        logic [31:0] exp_d;
        bit          exp_err;
        bit          exp_mis;
        exp_d   = '0;
        exp_err = 1'b0;
        exp_mis = ref_misaligned(size, offs);
        check_val("idle_reqReady", bus.reqReady, 1);
        bus.mRead    = 1'b1;
        bus.Offs     = 2'(offs);
        bus.dSize    = 2'(size);
        bus.signExt  = sext;
        bus.memValid = 1'($urandom_range(0, 1));
        bus.memData  = $urandom;
        tick();
        bus.mRead    = 1'b0;
        bus.Offs     = 2'($urandom);
        bus.dSize    = 2'($urandom);
        bus.signExt  = 1'($urandom);
        bus.memValid = 1'b0;
        if (size == 3) begin
            exp_err = 1'b1;
        end else if (!exp_mis) begin
            for (int i = 0; i < TO; i++) begin
                check_val("wait_dValid", bus.dValid, 0);
                check_val("wait_reqReady", bus.reqReady, 0);
                bus.memValid = (i == lat);
                bus.memData  = (i == lat) ? data : $urandom;
                tick();
                if (i == lat) begin
                    exp_d = ref_load(data, size, offs, sext);
                    break;
                end
                if (i == TO - 1) exp_err = 1'b1;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            check_val("resp_dValid", bus.dValid, 1);
            check_val("resp_dOut", bus.dOut, exp_d);
            check_val("resp_busErr", bus.busErr, exp_err);
            check_val("resp_misAlign", bus.misAlign, exp_mis);
            check_val("resp_reqReady", bus.reqReady, 0);
            bus.dReady   = (h == hold);
            bus.memValid = 1'($urandom_range(0, 1));
            bus.memData  = $urandom;
            bus.mRead    = 1'($urandom_range(0, 1));
            tick();
        end
        bus.dReady   = 1'b0;
        bus.mRead    = 1'b0;
        bus.memValid = 1'b0;
        check_val("done_dValid", bus.dValid, 0);
        check_val("done_busErr", bus.busErr, 0);
        check_val("done_misAlign", bus.misAlign, 0);
        check_val("done_reqReady", bus.reqReady, 1);
        bus.memValid = 1'b1;
        bus.memData  = $urandom;
        tick();
        bus.memValid = 1'b0;
        check_val("idle_memValid_ignored", bus.dValid, 0);
    endtask

    initial begin
        bus.mRead    = 1'b0;
        bus.Offs     = 2'b00;
        bus.dSize    = 2'b00;
        bus.signExt  = 1'b0;
        bus.memData  = '0;
        bus.memValid = 1'b0;
        bus.dReady   = 1'b0;
        rst_n        = 1'b0;
        tick();
        tick();
        check_val("rst_reqReady", bus.reqReady, 0);
        check_val("rst_dValid", bus.dValid, 0);
        check_val("rst_dOut", bus.dOut, 0);
        check_val("rst_busErr", bus.busErr, 0);
        check_val("rst_misAlign", bus.misAlign, 0);
        rst_n = 1'b1;
        tick();

        // Byte and halfword examples, word with slow consumer, timeout.
        do_load(2, 1, 1'b1, 32'hAABBCCDD, 0, 0);
        do_load(2, 1, 1'b0, 32'hAABBCCDD, 1, 1);
        do_load(1, 2, 1'b1, 32'hAABBCCDD, 0, 0);
        do_load(1, 0, 1'b0, 32'hAABBCCDD, 2, 0);
        do_load(0, 0, 1'b0, 32'hAABBCCDD, 2, 4);
        do_load(0, 0, 1'b0, 32'h12345678, 10, 2);
        do_load(2, 3, 1'b1, 32'h0000007F, TO - 1, 0);
        do_load(1, 1, 1'b1, 32'hAABBCCDD, 0, 1);
        do_load(3, 2, 1'b1, 32'hFFFFFFFF, 0, 1);

        // Reset while waiting for memory abandons the load.
        bus.mRead = 1'b1;
        bus.dSize = 2'b00;
        bus.Offs  = 2'b00;
        tick();
        bus.mRead = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_val("rstwait_dValid", bus.dValid, 0);
        check_val("rstwait_reqReady", bus.reqReady, 0);
        check_val("rstwait_dOut", bus.dOut, 0);
        rst_n        = 1'b1;
        bus.memValid = 1'b1;
        bus.memData  = 32'hDEADBEEF;
        tick();
        bus.memValid = 1'b0;
        check_val("rstwait_late_dValid", bus.dValid, 0);
        check_val("rstwait_reqReady_back", bus.reqReady, 1);

        // Reset while holding a response.
        bus.mRead = 1'b1;
        bus.dSize = 2'b10;
        bus.Offs  = 2'b00;
        tick();
        bus.mRead    = 1'b0;
        bus.memValid = 1'b1;
        bus.memData  = 32'h80000000;
        tick();
        bus.memValid = 1'b0;
        check_val("rstresp_pre_dValid", bus.dValid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("rstresp_dValid", bus.dValid, 0);
        check_val("rstresp_dOut", bus.dOut, 0);
        tick();

        for (int n = 0; n < 150; n++) begin
            do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom), $urandom, int'($urandom_range(0, TO + 1)),
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
